// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control unit for a MIPS subset (FETCH/DECODE/EXEC/MEM/WB).
// Control outputs decode combinationally from state and instruction fields; instr_cnt counts retirements.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        PCWr,
  output logic [1:0]  PCsrc,
  output logic        IRWr,
  output logic        RegWr,
  output logic        MemWr,
  output logic        ALUSrc,
  output logic        ExtOp,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUOp,
  output logic [2:0]  state,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t cur, nxt;

  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal;
  logic illegal;
  logic pc_wr, ir_wr, reg_wr, mem_wr;
  logic retire;

  always_comb begin
    is_r    = (opcode == 6'b000000);
    is_addu = is_r && (funct == 6'b100001);
    is_subu = is_r && (funct == 6'b100011);
    is_jr   = is_r && (funct == 6'b001000);
    is_ori  = (opcode == 6'b001101);
    is_lw   = (opcode == 6'b100011);
    is_sw   = (opcode == 6'b101011);
    is_beq  = (opcode == 6'b000100);
    is_lui  = (opcode == 6'b001111);
    is_j    = (opcode == 6'b000010);
    is_jal  = (opcode == 6'b000011);
    illegal = !(is_addu || is_subu || is_jr || is_ori || is_lw || is_sw ||
                is_beq || is_lui || is_j || is_jal);
  end

  always_comb begin
    nxt      = FETCH;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    reg_wr   = 1'b0;
    mem_wr   = 1'b0;
    PCsrc    = '0;
    ALUSrc   = 1'b0;
    ExtOp    = 1'b0;
    RegDst   = '0;
    MemtoReg = '0;
    ALUOp    = '0;

    // ALU controls stay at their EXEC values through MEM and WB to keep operands stable
    if (cur == EXEC || cur == MEM || cur == WB) begin
      ALUSrc = is_ori || is_lw || is_sw || is_lui;
      ExtOp  = is_lw || is_sw || is_beq;
      if (is_subu || is_beq)  ALUOp = 2'b01;
      else if (is_ori)        ALUOp = 2'b10;
      else if (is_lui)        ALUOp = 2'b11;
    end

    case (cur)
      FETCH: begin
        ir_wr = 1'b1;
        pc_wr = 1'b1;
        nxt   = DECODE;
      end
      DECODE: begin
        if (is_j || is_jal) begin
          pc_wr = 1'b1;
          PCsrc = 2'b10;
        end
        if (is_jal) begin
          reg_wr   = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
        if (is_jr) begin
          pc_wr = 1'b1;
          PCsrc = 2'b11;
        end
        nxt = (is_j || is_jal || is_jr || illegal) ? FETCH : EXEC;
      end
      EXEC: begin
        if (is_beq) begin
          PCsrc = 2'b01;
          pc_wr = zero;
          nxt   = FETCH;
        end else if (is_lw || is_sw) begin
          nxt = MEM;
        end else begin
          nxt = WB;
        end
      end
      MEM: begin
        mem_wr = is_sw;
        nxt    = is_lw ? WB : FETCH;
      end
      WB: begin
        reg_wr   = 1'b1;
        RegDst   = (is_addu || is_subu) ? 2'b01 : 2'b00;
        MemtoReg = is_lw ? 2'b01 : 2'b00;
        nxt      = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end

  assign retire = (cur != FETCH) && (nxt == FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= FETCH;
      instr_cnt <= '0;
    end else begin
      cur <= nxt;
      if (retire) instr_cnt <= instr_cnt + 32'd1;
    end
  end

  // Write enables are masked directly by reset so an aborted instruction cannot write
  assign PCWr  = pc_wr  && !reset;
  assign IRWr  = ir_wr  && !reset;
  assign RegWr = reg_wr && !reset;
  assign MemWr = mem_wr && !reset;
  assign state = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed cases then random instructions
// compared against a per-instruction-class behavioural model.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic        PCWr, IRWr, RegWr, MemWr, ALUSrc, ExtOp;
  logic [1:0]  PCsrc, RegDst, MemtoReg, ALUOp;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] model_cnt;

  localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LW = 4, C_SW = 5,
                 C_BEQ = 6, C_LUI = 7, C_J = 8, C_JAL = 9, C_ILL = 10;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWr(PCWr), .PCsrc(PCsrc), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr),
    .ALUSrc(ALUSrc), .ExtOp(ExtOp), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUOp(ALUOp), .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  wire [13:0] ctrl = {PCWr, PCsrc, IRWr, RegWr, MemWr, ALUSrc, ExtOp, RegDst, MemtoReg, ALUOp};
  wire [3:0]  wen  = {PCWr, IRWr, RegWr, MemWr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b100001) return C_ADDU;
        if (fn == 6'b100011) return C_SUBU;
        if (fn == 6'b001000) return C_JR;
        return C_ILL;
      end
      6'b001101: return C_ORI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b001111: return C_LUI;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic int latency(input int c);
    if (c == C_J || c == C_JAL || c == C_JR || c == C_ILL) return 2;
    if (c == C_BEQ) return 3;
    if (c == C_LW)  return 5;
    return 4;
  endfunction

  // Step k of an instruction: FETCH, DECODE, EXEC, then MEM for memory ops, then WB
  function automatic logic [2:0] exp_state(input int c, input int k);
    if (k <= 2) return 3'(k);
    if (k == 3 && (c == C_LW || c == C_SW)) return 3'd3;
    return 3'd4;
  endfunction

  function automatic logic [13:0] exp_ctrl(input int c, input logic [2:0] st, input logic z);
    logic       pcwr = 0, irwr = 0, regwr = 0, memwr = 0, alusrc = 0, extop = 0;
    logic [1:0] pcsrc = 0, regdst = 0, memtoreg = 0, aluop = 0;
    if (st >= 3'd2) begin
      alusrc = (c == C_ORI || c == C_LW || c == C_SW || c == C_LUI);
      extop  = (c == C_LW || c == C_SW || c == C_BEQ);
      aluop  = (c == C_SUBU || c == C_BEQ) ? 2'd1 : (c == C_ORI) ? 2'd2 : (c == C_LUI) ? 2'd3 : 2'd0;
    end
    case (st)
      3'd0: begin irwr = 1; pcwr = 1; end
      3'd1: begin
        if (c == C_J)   begin pcwr = 1; pcsrc = 2'd2; end
        if (c == C_JAL) begin pcwr = 1; pcsrc = 2'd2; regwr = 1; regdst = 2'd2; memtoreg = 2'd2; end
        if (c == C_JR)  begin pcwr = 1; pcsrc = 2'd3; end
      end
      3'd2: if (c == C_BEQ) begin pcsrc = 2'd1; pcwr = z; end
      3'd3: memwr = (c == C_SW);
      3'd4: begin
        regwr    = 1;
        regdst   = (c == C_ADDU || c == C_SUBU) ? 2'd1 : 2'd0;
        memtoreg = (c == C_LW) ? 2'd1 : 2'd0;
      end
      default: ;
    endcase
    return {pcwr, pcsrc, irwr, regwr, memwr, alusrc, extop, regdst, memtoreg, aluop};
  endfunction

  // Entered at negedge+1 with the DUT in FETCH; leaves at negedge+1 in the next FETCH
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int c = classify(op, fn);
    int n = latency(c);
    logic [2:0] es;
    opcode = op; funct = fn; zero = z;
    #1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      es = exp_state(c, k);
      chk($sformatf("state op=%b fn=%b k=%0d", op, fn, k), 32'(state), 32'(es));
      chk($sformatf("ctrl op=%b fn=%b z=%b k=%0d", op, fn, z, k), 32'(ctrl), 32'(exp_ctrl(c, es, z)));
    end
    @(negedge clk); #1;
    model_cnt = model_cnt + 32'd1;
    chk($sformatf("cnt op=%b", op), instr_cnt, model_cnt);
    chk("retire_state", 32'(state), 32'd0);
  endtask

  logic [5:0] op_tab [10] = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b100011,
                              6'b101011, 6'b000100, 6'b001111, 6'b000010, 6'b000011};
  logic [5:0] fn_tab [10] = '{6'b100001, 6'b100011, 6'b001000, 6'b0, 6'b0,
                              6'b0, 6'b0, 6'b0, 6'b0, 6'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    int sel, w;
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
    model_cnt = '0;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", instr_cnt, 32'd0);
    chk("rst_wen", 32'(wen), 32'd0);
    @(posedge clk); #1;
    chk("rst_state_clk", 32'(state), 32'd0);
    chk("rst_wen_clk", 32'(wen), 32'd0);
    @(negedge clk); reset = 1'b0; #1;

    run_instr(6'b000000, 6'b100001, 1'b0);  // addu
    run_instr(6'b000100, 6'b010101, 1'b1);  // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0);  // beq not taken
    run_instr(6'b100011, 6'b000000, 1'b0);  // lw
    run_instr(6'b101011, 6'b000000, 1'b1);  // sw
    run_instr(6'b000011, 6'b000000, 1'b0);  // jal
    run_instr(6'b000000, 6'b001000, 1'b0);  // jr
    run_instr(6'b111111, 6'b111111, 1'b1);  // illegal opcode
    run_instr(6'b000000, 6'b000000, 1'b0);  // illegal funct

    // Reset in the MEM step of a lw
    opcode = 6'b100011; funct = '0; zero = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk($sformatf("abort_state k=%0d", k), 32'(state), 32'(exp_state(C_LW, k)));
    end
    #2 reset = 1'b1; #1;
    chk("abort_async_state", 32'(state), 32'd0);
    chk("abort_async_cnt", instr_cnt, 32'd0);
    chk("abort_async_wen", 32'(wen), 32'd0);
    model_cnt = '0;
    @(posedge clk); #1;
    chk("abort_hold_wen", 32'(wen), 32'd0);
    chk("abort_hold_state", 32'(state), 32'd0);
    @(negedge clk); reset = 1'b0; #1;
    @(negedge clk); #1;
    chk("abort_first_fetch", 32'(state), 32'd1);
    w = 0;
    while (state != 3'd0 && w < 8) begin @(negedge clk); #1; w++; end
    chk("abort_resume_fetch", 32'(state), 32'd0);
    model_cnt = model_cnt + 32'd1;
    chk("abort_resume_cnt", instr_cnt, model_cnt);

    // Counter wrap
    force dut.instr_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.instr_cnt;
    model_cnt = 32'hFFFF_FFFF;
    chk("cnt_preset", instr_cnt, model_cnt);
    run_instr(6'b000010, 6'b000000, 1'b0);  // j wraps counter

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 11);
      fn  = 6'($urandom);
      if (sel < 10) begin
        op = op_tab[sel];
        if (op == 6'b000000) fn = fn_tab[sel];
      end else if (sel == 10) begin
        op = 6'($urandom);
        while (classify(op, fn) != C_ILL) op = 6'($urandom);
      end else begin
        op = 6'b000000;
        while (classify(op, fn) != C_ILL) fn = 6'($urandom);
      end
      run_instr(op, fn, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port opcode, input, 6 bits: IR[31:26]; valid from DECODE onward.
REQ-004 SHALL have port funct, input, 6 bits: IR[5:0]; valid from DECODE onward.
REQ-005 SHALL have port zero, input, 1 bit: ALU equality flag, sampled in EXEC.
REQ-006 SHALL have port PCWr, output, 1 bit: PC register write enable.
REQ-007 SHALL have port PCsrc, output, 2 bits: next-PC select; 00 pc+4, 01 beq, 10 j/jal, 11 jr.
REQ-008 SHALL have outputs IRWr, RegWr, MemWr, ALUSrc and ExtOp, 1 bit each: IR write, register-file write, data-memory write, ALU B = immediate, sign-extend (1) / zero-extend (0).
REQ-009 SHALL have outputs RegDst, MemtoReg and ALUOp, 2 bits each: RegDst 00 rt, 01 rd, 10 r31; MemtoReg 00 ALU, 01 mem, 10 PC; ALUOp 00 add, 01 sub, 10 or, 11 lui.
REQ-010 SHALL have port state, output, 3 bits: current FSM state.
REQ-011 SHALL have port instr_cnt, output, 32 bits: retired-instruction counter.

Function
REQ-012 SHALL use states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge.
REQ-013 SHALL decode opcode/funct: R-type 000000 with funct addu 100001, subu 100011, jr 001000; ori 001101; lw 100011; sw 101011; beq 000100; lui 001111; j 000010; jal 000011. Any other code is illegal.
REQ-014 SHALL drive all outputs combinationally from state, opcode, funct and zero (Moore except beq PCWr); unlisted outputs SHALL be 0.
REQ-015 FETCH: IRWr=1, PCWr=1, PCsrc=00; next state DECODE.
REQ-016 DECODE, j: PCWr=1, PCsrc=10; next FETCH.
REQ-017 DECODE, jal: PCWr=1, PCsrc=10, RegWr=1, RegDst=10, MemtoReg=10 (PC already holds link address); next FETCH.
REQ-018 DECODE, jr: PCWr=1, PCsrc=11; next FETCH.
REQ-019 DECODE, illegal instruction: no write enables; next FETCH (executes as nop, counted as retired).
REQ-020 DECODE, all other legal instructions: no write enables; next EXEC.
REQ-021 EXEC drives ALUSrc=1 for ori/lw/sw/lui and 0 otherwise; ExtOp=1 for lw/sw/beq; ALUOp add for addu/lw/sw, sub for subu/beq, or for ori, lui for lui.
REQ-022 EXEC, beq: PCsrc=01, PCWr=zero; next FETCH in both cases.
REQ-023 EXEC next state: lw/sw to MEM; addu/subu/ori/lui to WB.
REQ-024 MEM, sw: MemWr=1; next FETCH. MEM, lw: no write; next WB.
REQ-025 WB: RegWr=1. RegDst=01 for addu/subu, else 00. MemtoReg=01 for lw, else 00. Next FETCH.
REQ-026 SHALL hold ALUSrc/ExtOp/ALUOp at the EXEC values during MEM and WB so datapath operands stay stable.
REQ-027 instr_cnt SHALL increment by 1 on every edge whose next state is FETCH from a non-FETCH state; it SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 Per-instruction latency SHALL be: j/jal/jr/illegal 2 cycles; beq 3; sw, addu, subu, ori, lui 4; lw 5.

Reset
REQ-029 While reset=1, state SHALL be FETCH, instr_cnt 0, and PCWr, IRWr, RegWr and MemWr SHALL be forced to 0, independent of clk.
REQ-030 Reset asserted mid-instruction SHALL abort it immediately with no further writes; after deassertion, the first edge SHALL perform FETCH.

Verification
REQ-031 Reset, then addu (000000/100001) -> states 0,1,2,4,0; WB RegWr=1, RegDst=01; instr_cnt=1.
REQ-032 beq with zero=1, then beq with zero=0 -> EXEC PCsrc=01 with PCWr=1, then PCWr=0; each 3 cycles; instr_cnt +2.
REQ-033 lw then sw -> lw states 0,1,2,3,4 with WB MemtoReg=01, ExtOp=1; sw MEM MemWr=1 and RegWr=0 throughout.
REQ-034 jal -> DECODE PCWr=1, PCsrc=10, RegWr=1, RegDst=10, MemtoReg=10; jr -> DECODE PCsrc=11; each 2 cycles.
REQ-035 Opcode 111111 -> 2 cycles, no write enables in DECODE; reset pulsed in MEM of lw -> state 0 asynchronously, RegWr never asserted, instr_cnt=0.
REQ-036 instr_cnt preset via force to 0xFFFFFFFF, then j -> instr_cnt=0x00000000.
